// File: rtl/conv1_aer_spike_receiver.sv
// Conv-layer-1 AER spike receiver: buffers events in a FIFO and
// expands each one into a KxK scan of next-layer membrane updates.
module conv1_aer_spike_receiver #(
  parameter int K          = 3,
  parameter int VMEM_ROW   = 30,
  parameter int CH_NUM     = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4,
  parameter int WADDR_W    = 6
) (
  input  logic               work_clk,
  input  logic               rst_n,
  input  logic [17:0]        Conv_layer1_spike,
  input  logic               Conv_layer1_spike_emit_f,
  input  logic               frame_end,
  output logic               operating_flag,
  output logic [15:0]        Vmem_ram_address,
  output logic [WADDR_W-1:0] Weight_rom_address,
  output logic [7:0]         Location_M,
  output logic [7:0]         Location_N,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               fifo_full,
  output logic               overflow_err,
  output logic               busy,
  output logic               frame_done
);

  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam int CW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam logic [FIFO_AW:0] CNT_ONE = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW:0] CNT_MAX = (FIFO_AW+1)'(FIFO_DEPTH);
  localparam logic [IW-1:0] LAST = IW'(K - 1);
  localparam logic [15:0] ROW16 = 16'(VMEM_ROW);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SCAN
  } state_t;

  state_t state, state_n;

  logic [17:0]        mem [FIFO_DEPTH];
  logic [17:0]        head;
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count_n;
  logic               pop, push, more, last_upd;
  logic               pend, done_c;

  logic [CW-1:0]      scan_ch;
  logic [7:0]         scan_m, scan_n;
  logic [IW-1:0]      i_cnt, j_cnt;
  logic [7:0]         loc_m, loc_n;
  logic [15:0]        vmem_n;
  logic [WADDR_W-1:0] waddr_n;

  assign head = mem[rd_ptr];

  always_comb begin
    pop      = (state == LOAD);
    push     = Conv_layer1_spike_emit_f && (!fifo_full || pop);
    more     = (fifo_count != '0) || push;
    last_upd = (state == SCAN) && (i_cnt == LAST) && (j_cnt == LAST);
    count_n  = fifo_count;
    if (push && !pop) begin
      count_n = fifo_count + CNT_ONE;
    end else if (!push && pop) begin
      count_n = fifo_count - CNT_ONE;
    end
    state_n = state;
    unique case (state)
      IDLE:    if (more) state_n = LOAD;
      LOAD:    state_n = SCAN;
      SCAN:    if (last_upd) state_n = more ? LOAD : IDLE;
      default: state_n = IDLE;
    endcase
    done_c = pend && (state == IDLE) && (fifo_count == '0)
          && !Conv_layer1_spike_emit_f;
  end

  // update address arithmetic; locations wrap mod 256 by width
  always_comb begin
    loc_m   = scan_m + 8'(i_cnt);
    loc_n   = scan_n + 8'(j_cnt);
    vmem_n  = 16'(loc_m) * ROW16 + 16'(loc_n);
    waddr_n = WADDR_W'(scan_ch) * WADDR_W'(K * K)
            + WADDR_W'(i_cnt) * WADDR_W'(K)
            + WADDR_W'(j_cnt);
  end

  always_ff @(posedge work_clk) begin
    if (push) mem[wr_ptr] <= Conv_layer1_spike;
  end

  always_ff @(posedge work_clk) begin
    if (!rst_n) begin
      state              <= IDLE;
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      fifo_count         <= '0;
      fifo_full          <= 1'b0;
      overflow_err       <= 1'b0;
      busy               <= 1'b0;
      frame_done         <= 1'b0;
      pend               <= 1'b0;
      scan_ch            <= '0;
      scan_m             <= '0;
      scan_n             <= '0;
      i_cnt              <= '0;
      j_cnt              <= '0;
      operating_flag     <= 1'b0;
      Vmem_ram_address   <= '0;
      Weight_rom_address <= '0;
      Location_M         <= '0;
      Location_N         <= '0;
    end else begin
      state      <= state_n;
      fifo_count <= count_n;
      fifo_full  <= (count_n == CNT_MAX);
      busy       <= (state_n != IDLE) || (count_n != '0);
      frame_done <= done_c;
      if (frame_end) begin
        pend <= 1'b1;
      end else if (done_c) begin
        pend <= 1'b0;
      end
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (Conv_layer1_spike_emit_f && !push) overflow_err <= 1'b1;
      operating_flag <= 1'b0;
      if (pop) begin
        rd_ptr  <= rd_ptr + FIFO_AW'(1);
        scan_ch <= head[17:16];
        scan_m  <= head[15:8];
        scan_n  <= head[7:0];
        i_cnt   <= '0;
        j_cnt   <= '0;
      end
      if (state == SCAN) begin
        operating_flag     <= 1'b1;
        Location_M         <= loc_m;
        Location_N         <= loc_n;
        Vmem_ram_address   <= vmem_n;
        Weight_rom_address <= waddr_n;
        if (j_cnt == LAST) begin
          j_cnt <= '0;
          i_cnt <= i_cnt + IW'(1);
        end else begin
          j_cnt <= j_cnt + IW'(1);
        end
      end
    end
  end

endmodule
